// File: rtl/mem_arb_pkg.sv
// Shared types for the 6502 / DMA memory-bus arbiter.
package mem_arb_pkg;
  typedef enum logic {OWN_CPU = 1'b0, OWN_DMA = 1'b1} owner_e;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
endpackage

// File: rtl/mem_bus_arbiter.sv
// Single-owner arbiter sharing a sync-read RAM between the 6502 core and a DMA port.
// Read data returns one cycle after the beat; the core is back-pressured via cpu_rdy while DMA owns the bus.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DMA_MAX_BURST = 4,
  parameter int CPU_MIN_SLOT  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_ab,
  input  logic [DATA_W-1:0] cpu_do,
  input  logic              cpu_we,
  output logic [DATA_W-1:0] cpu_di,
  output logic              cpu_rdy,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic              dma_we,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int BW = $clog2(DMA_MAX_BURST + 1);
  localparam int DW = $clog2(CPU_MIN_SLOT + 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(DMA_MAX_BURST - 1);
  localparam logic [DW-1:0] DWELL_SAT  = DW'(CPU_MIN_SLOT);
  // The CPU cycle in progress counts toward the slot, so CPU_MIN_SLOT cycles are guaranteed.
  localparam logic [DW-1:0] DWELL_GO   = DW'(CPU_MIN_SLOT - 1);

  owner_e            own_q, own_d;
  logic [BW-1:0]     burst_cnt_q, burst_cnt_d;
  logic [DW-1:0]     dwell_cnt_q, dwell_cnt_d;
  logic              cpu_beat_q, cpu_beat_d;
  logic              dma_rd_q, dma_rd_d;
  logic [DATA_W-1:0] cpu_di_hold_q, cpu_di_hold_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      own_q         <= OWN_CPU;
      burst_cnt_q   <= '0;
      dwell_cnt_q   <= DWELL_SAT;
      cpu_beat_q    <= 1'b0;
      dma_rd_q      <= 1'b0;
      cpu_di_hold_q <= '0;
    end else begin
      own_q         <= own_d;
      burst_cnt_q   <= burst_cnt_d;
      dwell_cnt_q   <= dwell_cnt_d;
      cpu_beat_q    <= cpu_beat_d;
      dma_rd_q      <= dma_rd_d;
      cpu_di_hold_q <= cpu_di_hold_d;
    end
  end

  always_comb begin
    own_d       = own_q;
    burst_cnt_d = burst_cnt_q;
    dwell_cnt_d = dwell_cnt_q;
    case (own_q)
      OWN_CPU: begin
        if (dma_req && (dwell_cnt_q >= DWELL_GO)) begin
          own_d       = OWN_DMA;
          burst_cnt_d = '0;
        end else if (dwell_cnt_q < DWELL_SAT) begin
          dwell_cnt_d = dwell_cnt_q + 1'b1;
        end
      end
      OWN_DMA: begin
        if (!dma_req || (burst_cnt_q == BURST_LAST)) begin
          own_d       = OWN_CPU;
          dwell_cnt_d = '0;
        end else begin
          burst_cnt_d = burst_cnt_q + 1'b1;
        end
      end
      default: own_d = OWN_CPU;
    endcase
  end

  always_comb begin
    mem_addr  = cpu_ab;
    mem_wdata = cpu_do;
    mem_we    = cpu_we;
    cpu_rdy   = 1'b1;
    dma_gnt   = 1'b0;
    if (own_q == OWN_DMA) begin
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      mem_we    = dma_req & dma_we;
      cpu_rdy   = 1'b0;
      dma_gnt   = dma_req;
    end
  end

  // Read-return tracking: the core sees held data across stalls, DMA sees a one-cycle valid.
  always_comb begin
    cpu_beat_d    = (own_q == OWN_CPU);
    dma_rd_d      = dma_gnt & ~dma_we;
    cpu_di_hold_d = cpu_beat_q ? mem_rdata : cpu_di_hold_q;
  end

  assign cpu_di     = cpu_beat_q ? mem_rdata : cpu_di_hold_q;
  assign dma_rvalid = dma_rd_q;
  assign dma_rdata  = mem_rdata;

endmodule
